// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared FSM encoding and truth-table constants for gate_tt_checker
package gate_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Truth tables indexed by {a,b}
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam int DEF_SETTLE_CYC = 2;

endpackage

// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - sweeps a 2-input gate through 00,01,10,11 and checks y against EXP_TT
// Optional macro GATE_TT_CAPTURE_EN adds the obs_tt capture of observed y values.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter logic [3:0] EXP_TT     = TT_OR,
    parameter int         SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef GATE_TT_CAPTURE_EN
    ,
    output logic [3:0] obs_tt
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_idx;
    logic [1:0] w_idx_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       r_a;
    logic       r_b;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic       w_accept;
    logic       w_mismatch;
    logic       w_drive;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_mismatch = (r_state == ST_SAMPLE) && (y != EXP_TT[r_idx]);
    assign w_drive    = (w_next == ST_APPLY) || (w_next == ST_SAMPLE);

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next     = ST_APPLY;
                    w_idx_next = 2'd0;
                    w_cnt_next = 4'd0;
                end
            end
            ST_APPLY: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_next     = ST_SAMPLE;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (r_idx == 2'd3) begin
                    w_next = ST_DONE;
                end else begin
                    w_next     = ST_APPLY;
                    w_idx_next = r_idx + 2'd1;
                end
            end
            ST_DONE: begin
                w_next     = ST_IDLE;
                w_idx_next = 2'd0;
            end
            default: begin
                w_next     = ST_IDLE;
                w_idx_next = 2'd0;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // a/b are loaded from the next vector so they are stable for the whole APPLY window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_a     <= w_drive & w_idx_next[1];
            r_b     <= w_drive & w_idx_next[0];
            r_done  <= (r_state == ST_DONE);
            if (w_accept) begin
                r_err  <= 3'd0;
                r_pass <= 1'b0;
            end else if (w_mismatch && (r_err != 3'd4)) begin
                r_err <= r_err + 3'd1;
            end
            if (r_state == ST_DONE) begin
                r_pass <= (r_err == 3'd0);
            end
        end
    end

`ifdef GATE_TT_CAPTURE_EN
    logic [3:0] r_obs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_obs <= 4'd0;
        end else if (w_accept) begin
            r_obs <= 4'd0;
        end else if (r_state == ST_SAMPLE) begin
            r_obs[r_idx] <= y;
        end
    end

    assign obs_tt = r_obs;
`endif

    assign a       = r_a;
    assign b       = r_b;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - randomized gate sweeps checked against a truth-table reference model
module tb_gate_tt_checker;
    import gate_tt_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [3:0] g0 = TT_OR;
    logic [3:0] g1 = TT_XOR;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
`ifdef GATE_TT_CAPTURE_EN
    logic [3:0] obs0, obs1;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Emulated gates under test
    always_comb y0 = g0[{a0, b0}];
    always_comb y1 = g1[{a1, b1}];

    gate_tt_checker #(.EXP_TT(TT_OR), .SETTLE_CYC(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_TT_CAPTURE_EN
        , .obs_tt(obs0)
`endif
    );

    gate_tt_checker #(.EXP_TT(TT_XOR), .SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_TT_CAPTURE_EN
        , .obs_tt(obs1)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete sweep; expected waveform derived from vector k occupying s+1 cycles
    task automatic sweep(input bit sel, input logic [3:0] g, input int s,
                         input logic [3:0] exp_tt, input bit poke);
        int       len;
        int       k;
        logic [1:0] v;
        len = 4 * (s + 1) + 1;
        @(posedge clk); #1;
        if (sel) begin g1 = g; start1 = 1'b1; end else begin g0 = g; start0 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        chk("busy_accept", sel ? busy1 : busy0, 1'b1);
        for (int n = 1; n <= len; n++) begin
            @(posedge clk); #1;
            k = n / (s + 1);
            v = (k < 4) ? 2'(k) : 2'd0;
            chk("a_walk", sel ? a1 : a0, v[1]);
            chk("b_walk", sel ? b1 : b0, v[0]);
            chk("done_time", sel ? done1 : done0, n == len);
            chk("busy_span", sel ? busy1 : busy0, n < len);
            if (poke && n == 3) start0 = 1'b1;
            if (poke && n == 4) start0 = 1'b0;
        end
        chk("err_cnt", sel ? err1 : err0, 8'($countones(g ^ exp_tt)));
        chk("pass", sel ? pass1 : pass0, g == exp_tt);
`ifdef GATE_TT_CAPTURE_EN
        chk("obs_tt", sel ? obs1 : obs0, g);
`endif
        @(posedge clk); #1;
        chk("done_single", sel ? done1 : done0, 1'b0);
        chk("pass_hold", sel ? pass1 : pass0, g == exp_tt);
    endtask

    initial begin
        int  d_first;
        int  d_second;
        int  cyc;
        bit  seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", a0, 1'b0);
        chk("rst_b", b0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_pass", pass0, 1'b0);
        chk("rst_err", err0, 3'd0);
        rst_n = 1'b1;

        // Directed: OR passes, AND gives 2 errors, NOR saturates at 4
        sweep(1'b0, TT_OR, 2, TT_OR, 1'b0);
        sweep(1'b0, TT_AND, 2, TT_OR, 1'b0);
        sweep(1'b0, TT_NOR, 2, TT_OR, 1'b0);
        // Start pulsed while busy is ignored
        sweep(1'b0, TT_OR, 2, TT_OR, 1'b1);
        repeat (15) begin
            @(posedge clk); #1;
            chk("no_restart", done0 | busy0, 1'b0);
        end

        // Randomized gates on both instances
        for (int i = 0; i < 6; i++) sweep(1'b0, 4'($urandom_range(0, 15)), 2, TT_OR, 1'b0);
        sweep(1'b1, TT_XOR, 1, TT_XOR, 1'b0);
        for (int i = 0; i < 3; i++) sweep(1'b1, 4'($urandom_range(0, 15)), 1, TT_XOR, 1'b0);

        // Reset during vector 2 APPLY
        @(posedge clk); #1;
        g0 = TT_NOR; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_a", a0, 1'b1);
        chk("mid_err", err0, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_a", a0, 1'b0);
        chk("abort_b", b0, 1'b0);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_err", err0, 3'd0);
        chk("abort_pass", pass0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0 || busy0) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        sweep(1'b0, TT_OR, 2, TT_OR, 1'b0);

        // Start held high: back-to-back sweeps
        @(posedge clk); #1;
        g0 = TT_OR; start0 = 1'b1;
        d_first = -1; d_second = -1;
        for (int n = 0; n <= 27; n++) begin
            @(posedge clk); #1;
            if (done0) begin
                if (d_first < 0) d_first = n; else if (d_second < 0) d_second = n;
            end
            if (n == 27) start0 = 1'b0;
        end
        chk("b2b_first", 8'(d_first), 8'd13);
        chk("b2b_gap", 8'(d_second - d_first), 8'd14);
        cyc = 0;
        while (busy0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_idle", busy0, 1'b0);
        chk("b2b_pass", pass0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 Parameter EXP_TT, default 4'b1110, expected 2-input truth table; bit index = {a,b}; default is OR.
REQ-002 Parameter SETTLE_CYC, default 2, cycles each input vector is held before y is sampled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request one truth-table sweep; sampled only in IDLE.
REQ-006 a  output  1  DUT input a, registered.
REQ-007 b  output  1  DUT input b, registered.
REQ-008 y  input  1  DUT output under test.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-010 done  output  1  single-cycle pulse at end of sweep.
REQ-011 pass  output  1  sweep result, valid from done until next accepted start.
REQ-012 err_cnt  output  3  mismatch count of last/current sweep, 0..4.

Function
REQ-013 FSM states: IDLE, APPLY, SAMPLE, DONE.
REQ-014 IDLE: start=1 -> APPLY; vector index idx=0; err_cnt=0; pass=0; settle counter=0.
REQ-015 IDLE: start=0 -> stay; outputs hold.
REQ-016 APPLY: a=idx[1], b=idx[0]; held SETTLE_CYC cycles, then -> SAMPLE.
REQ-017 SAMPLE: compare y with EXP_TT[idx]; mismatch -> err_cnt+1 (saturates at 4; unreachable above 4 by construction).
REQ-018 SAMPLE with idx<3 -> idx+1, APPLY; idx=3 -> DONE.
REQ-019 DONE: done=1 for one cycle; pass=(final err_cnt==0); -> IDLE.
REQ-020 Vector order fixed: {a,b}=00,01,10,11.
REQ-021 done asserted exactly 4*(SETTLE_CYC+1)+1 cycles after the edge where start was sampled high.
REQ-022 start while busy or in DONE ignored; no restart, no queuing.
REQ-023 start high continuously in IDLE -> back-to-back sweeps, one IDLE cycle between sweeps.
REQ-024 a,b driven 0 in IDLE and DONE.
REQ-025 y ignored outside SAMPLE.

Reset
REQ-026 rst_n low, any state, incl. mid-sweep -> IDLE immediately; a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, idx=0, counter=0.
REQ-027 No done pulse generated by reset; aborted sweep leaves no result.

Configuration
REQ-028 Macro GATE_TT_CAPTURE_EN defined: extra output obs_tt [3:0]; bit idx loaded with y in SAMPLE; cleared on accepted start and reset; held after DONE.
REQ-029 Macro undefined: no obs_tt port, no capture register; all other behaviour identical.

Structure
REQ-030 Shared package gate_tt_pkg: FSM state encoding (2-bit), OR/AND/XOR/NAND/NOR/XNOR truth-table constants (4-bit), default SETTLE_CYC.
REQ-031 Single module, no sub-module; settle counter width 4 bits.

Verification
REQ-032 EXP_TT=OR, DUT=or gate, start pulse -> a,b walk 00,01,10,11; done at cycle 13 (SETTLE_CYC=2); pass=1; err_cnt=0.
REQ-033 EXP_TT=OR, DUT=and gate -> done, pass=0, err_cnt=2; obs_tt=4'b1000 with GATE_TT_CAPTURE_EN.
REQ-034 y tied 1, EXP_TT=4'b0000 -> err_cnt=4, pass=0, no overflow.
REQ-035 rst_n low during vector 2 APPLY -> a=b=0, busy=0, err_cnt=0 within same cycle; no done; new start gives full correct sweep.
REQ-036 start pulsed during busy -> ignored, single done; start held high -> two sweeps, done pulses 14 cycles apart.
REQ-037 SETTLE_CYC=1 -> done at cycle 9; each vector held exactly 1 cycle before sampling.
